// File: rtl/mem_bridge.sv
// mem_bridge: single-outstanding bridge between a multicycle CPU datapath and
// an external handshaked memory.
//
// The bridge captures a read or write request from the controller, presents
// it on the external bus until mem_ack arrives, then returns the read byte on
// memdata and merges it into the selected instruction-register byte lanes.
// While an access is in progress, stall tells the controller to hold its state.
//
// Optional feature: define MEM_BRIDGE_TIMEOUT_EN to abort an access that has
// been waiting TIMEOUT_CYCLES BUSY cycles without mem_ack. An aborted access
// returns memdata=8'hFF and sets the sticky timeout flag. Without the macro,
// BUSY waits forever for mem_ack and timeout is tied low.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   memread    : read request from the controller
//   memwrite   : write request from the controller (wins over memread)
//   adr        : request address
//   writedata  : store data
//   irwrite    : one-hot IR byte-lane enables, applied on read completion
//   mem_req    : external request strobe (high during BUSY)
//   mem_we     : external write enable, valid with mem_req
//   mem_addr   : external address, holds the last captured value
//   mem_wdata  : external write data, holds the last captured value
//   mem_rdata  : external read data, sampled on mem_ack
//   mem_ack    : external completion pulse; ignored outside BUSY
//   memdata    : last completed read byte
//   instr      : assembled instruction register
//   op         : opcode field instr[31:26]
//   stall      : controller must hold its state while high
//   timeout    : sticky access-abort flag
module mem_bridge #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] adr,
  input  logic [7:0]        writedata,
  input  logic [3:0]        irwrite,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        memdata,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic              stall,
  output logic              timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [7:0]          wdata_reg;
  logic                we_reg;
  logic [3:0]          lanes_reg;
  logic [7:0]          memdata_reg;

  logic                capture;    // accept a request this cycle
  logic                load_read;  // read completes this cycle
  logic                abort;      // access abandoned by the wait limit

  logic                request;
  assign request = memread | memwrite;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_reg;
  logic       timeout_reg;
  logic       tmo_hit;
  // The current BUSY cycle is the TIMEOUT_CYCLES-th one without ack.
  assign tmo_hit = (wait_cnt_reg == TMO_LAST);
`endif

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    load_read  = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (request) begin
          capture    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          load_read  = ~we_reg;
          state_next = DONE;
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        else if (tmo_hit) begin
          abort      = 1'b1;
          state_next = DONE;
        end
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      we_reg      <= 1'b0;
      lanes_reg   <= '0;
      memdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        addr_reg  <= adr;
        wdata_reg <= writedata;
        we_reg    <= memwrite;  // write wins when both requests are high
        lanes_reg <= irwrite;
      end
      if (load_read)
        memdata_reg <= mem_rdata;
      else if (abort)
        memdata_reg <= 8'hFF;
    end
  end

  // One register per IR byte lane; each loads only on a completed read with
  // its captured enable set.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        lane_reg <= '0;
      else if (load_read && lanes_reg[gi])
        lane_reg <= mem_rdata;
    end
    assign instr[8*gi +: 8] = lane_reg;
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      if (capture)
        wait_cnt_reg <= '0;
      else if (state_reg == BUSY && !mem_ack)
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      if (abort)
        timeout_reg <= 1'b1;
    end
  end
  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  // Bus outputs decode the state directly, so an asynchronous reset drops
  // mem_req in the same cycle.
  assign mem_req   = (state_reg == BUSY);
  assign mem_we    = (state_reg == BUSY) & we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign memdata   = memdata_reg;
  assign op        = instr[31:26];
  assign stall     = ((state_reg == IDLE) & request) | (state_reg == BUSY);

endmodule

// File: tb/tb_mem_bridge.sv
// Testbench for mem_bridge: directed scenarios plus randomized accesses
// checked against a transaction-level model of memdata, instr and timeout.
module tb_mem_bridge;

  logic        clk;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [7:0]  adr;
  logic [7:0]  writedata;
  logic [3:0]  irwrite;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [7:0]  memdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        stall;
  logic        timeout;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  // Reference model state
  logic [7:0]  exp_memdata = 8'h00;
  logic [31:0] exp_instr   = 32'h0;
  logic        exp_timeout = 1'b0;

  mem_bridge #(.ADDR_W(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .irwrite(irwrite),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .memdata(memdata), .instr(instr), .op(op), .stall(stall),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One complete access; ack arrives on the (delay+1)-th mem_req cycle.
  task automatic do_access(input bit rd, input bit wr, input logic [7:0] a,
                           input logic [7:0] wd, input logic [3:0] irw,
                           input int delay, input logic [7:0] rdata);
    int stall_cnt;
    @(negedge clk);
    memread = rd; memwrite = wr; adr = a; writedata = wd; irwrite = irw;
    #1;
    check_val("req_stall", 32'(stall), 32'(1));
    check_val("req_idle_memreq", 32'(mem_req), 32'(0));
    stall_cnt = 1;
    @(negedge clk);
    // Scramble inputs to confirm the bridge uses its captured copy.
    memread = 0; memwrite = 0;
    adr = 8'($urandom); writedata = 8'($urandom); irwrite = 4'($urandom);
    for (int i = 0; i <= delay; i++) begin
      check_val("busy_req", 32'(mem_req), 32'(1));
      check_val("busy_we", 32'(mem_we), 32'(wr));
      check_val("busy_addr", 32'(mem_addr), 32'(a));
      check_val("busy_wdata", 32'(mem_wdata), 32'(wd));
      if (stall) stall_cnt++;
      if (i == delay) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 8'($urandom);
    end
    if (rd && !wr) begin
      exp_memdata = rdata;
      for (int k = 0; k < 4; k++)
        if (irw[k]) exp_instr[8*k +: 8] = rdata;
    end
    check_val("done_req", 32'(mem_req), 32'(0));
    check_val("done_we", 32'(mem_we), 32'(0));
    check_val("done_stall", 32'(stall), 32'(0));
    check_val("done_addr_hold", 32'(mem_addr), 32'(a));
    check_val("memdata", 32'(memdata), 32'(exp_memdata));
    check_val("instr", instr, exp_instr);
    check_val("op", 32'(op), 32'(exp_instr[31:26]));
    check_val("timeout", 32'(timeout), 32'(exp_timeout));
    check_val("stall_cycles", 32'(stall_cnt), 32'(delay + 2));
    @(negedge clk);
    check_val("idle_stall", 32'(stall), 32'(0));
    check_val("idle_req", 32'(mem_req), 32'(0));
  endtask

  initial begin
    int busy_cnt;
    int kind;
    rst = 1'b1; memread = 0; memwrite = 0; adr = 0; writedata = 0;
    irwrite = 0; mem_rdata = 0; mem_ack = 0;
    repeat (2) @(negedge clk);
    check_val("rst_memreq", 32'(mem_req), 32'(0));
    check_val("rst_memwe", 32'(mem_we), 32'(0));
    check_val("rst_addr", 32'(mem_addr), 32'(0));
    check_val("rst_wdata", 32'(mem_wdata), 32'(0));
    check_val("rst_memdata", 32'(memdata), 32'(0));
    check_val("rst_instr", instr, 32'h0);
    check_val("rst_timeout", 32'(timeout), 32'(0));
    check_val("rst_stall", 32'(stall), 32'(0));
    rst = 1'b0;

    // Single read into lane 0; four stall cycles.
    do_access(1, 0, 8'h10, 8'h00, 4'b0001, 2, 8'hA5);
    check_val("dir_instr_lo", 32'(instr[7:0]), 32'h A5);

    // Four back-to-back lane reads assemble a full word.
    do_access(1, 0, 8'h00, 8'h00, 4'b0001, 0, 8'h20);
    do_access(1, 0, 8'h01, 8'h00, 4'b0010, 1, 8'h00);
    do_access(1, 0, 8'h02, 8'h00, 4'b0100, 0, 8'h01);
    do_access(1, 0, 8'h03, 8'h00, 4'b1000, 3, 8'h80);
    check_val("dir_word", instr, 32'h80010020);
    check_val("dir_op", 32'(op), 32'(6'b100000));

    // Simultaneous read and write: write wins.
    do_access(1, 1, 8'h44, 8'h5A, 4'b1111, 0, 8'hEE);
    check_val("dir_both_memdata", 32'(memdata), 32'(8'h80));

    // Read with no lanes enabled updates only memdata.
    do_access(1, 0, 8'h21, 8'h00, 4'b0000, 1, 8'h3C);

    // Randomized accesses.
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 2));
      do_access(kind != 1, kind != 0, 8'($urandom), 8'($urandom),
                4'($urandom), int'($urandom_range(0, 5)), 8'($urandom));
    end

    // Ack while idle is ignored.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = ~exp_memdata;
    @(negedge clk);
    mem_ack = 1'b0;
    check_val("stray_ack_memdata", 32'(memdata), 32'(exp_memdata));
    check_val("stray_ack_req", 32'(mem_req), 32'(0));

    // Reset during BUSY.
    @(negedge clk);
    memread = 1; adr = 8'h77; irwrite = 4'b1111;
    @(negedge clk);
    memread = 0;
    check_val("rst_busy_req_before", 32'(mem_req), 32'(1));
    #2 rst = 1'b1;
    #1;
    check_val("rst_busy_req", 32'(mem_req), 32'(0));
    check_val("rst_busy_instr", instr, 32'h0);
    check_val("rst_busy_memdata", 32'(memdata), 32'(0));
    exp_memdata = 8'h00; exp_instr = 32'h0; exp_timeout = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h99;
    @(negedge clk);
    mem_ack = 1'b0;
    check_val("late_ack_memdata", 32'(memdata), 32'(0));
    check_val("late_ack_instr", instr, 32'h0);
    check_val("late_ack_req", 32'(mem_req), 32'(0));

    do_access(1, 0, 8'h05, 8'h00, 4'b0110, 1, 8'h6D);

    // Access that never gets an ack.
    @(negedge clk);
    memread = 1; adr = 8'hC0; irwrite = 4'b1111;
    @(negedge clk);
    memread = 0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_req) break;
      busy_cnt++;
      @(negedge clk);
    end
`ifdef MEM_BRIDGE_TIMEOUT_EN
    exp_memdata = 8'hFF; exp_timeout = 1'b1;
    check_val("tmo_busy_cycles", 32'(busy_cnt), 32'(4));
    check_val("tmo_memdata", 32'(memdata), 32'(exp_memdata));
    check_val("tmo_flag", 32'(timeout), 32'(1));
    check_val("tmo_instr", instr, exp_instr);
    check_val("tmo_stall", 32'(stall), 32'(0));
    do_access(0, 1, 8'h12, 8'h34, 4'b0000, 0, 8'h00);
    check_val("tmo_sticky", 32'(timeout), 32'(1));
`else
    check_val("notmo_busy_cycles", 32'(busy_cnt), 32'(20));
    check_val("notmo_flag", 32'(timeout), 32'(0));
`endif
    #2 rst = 1'b1;
    #1;
    check_val("final_rst_timeout", 32'(timeout), 32'(0));
    check_val("final_rst_req", 32'(mem_req), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_memdata = 8'h00; exp_instr = 32'h0; exp_timeout = 1'b0;
    do_access(1, 0, 8'h08, 8'h00, 4'b1000, 2, 8'hFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter ADDR_W, default 8, width of memory address.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, BUSY cycles without ack before abort (used only with MEM_BRIDGE_TIMEOUT_EN).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 memread  input  1  read request from controller.
REQ-006 memwrite  input  1  write request from controller.
REQ-007 adr  input  ADDR_W  request address from datapath.
REQ-008 writedata  input  8  store data from datapath.
REQ-009 irwrite  input  4  one-hot IR byte-lane enables from controller.
REQ-010 mem_req  output  1  external memory request strobe.
REQ-011 mem_we  output  1  external write enable, valid with mem_req.
REQ-012 mem_addr  output  ADDR_W  external address, valid with mem_req.
REQ-013 mem_wdata  output  8  external write data, valid with mem_req.
REQ-014 mem_rdata  input  8  external read data, sampled on mem_ack.
REQ-015 mem_ack  input  1  external completion, one-cycle pulse.
REQ-016 memdata  output  8  last completed read byte, registered.
REQ-017 instr  output  32  assembled instruction register.
REQ-018 op  output  6  instr[31:26], combinational.
REQ-019 stall  output  1  controller must hold its state while high.
REQ-020 timeout  output  1  sticky access-abort flag.

Function
REQ-021 FSM states IDLE, BUSY, DONE; only these three encodings reachable.
REQ-022 IDLE: memread or memwrite high -> capture adr, writedata, irwrite, type (write if memwrite) into internal registers, go BUSY next edge.
REQ-023 memread and memwrite both high: write wins, read ignored, irwrite captured but unused.
REQ-024 BUSY: mem_req=1, mem_we/mem_addr/mem_wdata driven from captured registers, stable all BUSY cycles.
REQ-025 BUSY with mem_ack: read -> memdata<=mem_rdata and instr byte k<=mem_rdata for each captured irwrite[k] set (byte 0 = instr[7:0]); write -> memdata, instr unchanged; go DONE.
REQ-026 mem_ack outside BUSY ignored.
REQ-027 DONE: one cycle, mem_req=0, new requests not accepted, unconditional return to IDLE.
REQ-028 stall = (IDLE and (memread or memwrite)) or BUSY; low in DONE and idle IDLE.
REQ-029 Minimum access latency: request in IDLE cycle N, mem_req first high N+1, ack at N+1 -> DONE at N+2, stall low at N+2.
REQ-030 mem_req, mem_we low in IDLE and DONE; mem_addr, mem_wdata hold last captured values.
REQ-031 irwrite all-zero on a read: memdata updated, instr unchanged.

Reset
REQ-032 rst high asynchronously forces IDLE, memdata=0, instr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout=0, wait counter=0.
REQ-033 rst mid-BUSY drops mem_req in same cycle; late mem_ack after release ignored.

Configuration
REQ-034 Macro MEM_BRIDGE_TIMEOUT_EN defined: 8-bit counter cleared on IDLE->BUSY, increments each BUSY cycle without ack; reaching TIMEOUT_CYCLES -> go DONE, memdata<=8'hFF, instr unchanged, timeout<=1 (sticky until rst).
REQ-035 Macro undefined: BUSY waits indefinitely for mem_ack, no counter logic, timeout tied 0, port retained.

Verification
REQ-036 Read adr=8'h10, irwrite=4'b0001, mem_ack 3 cycles after mem_req, mem_rdata=8'hA5 -> instr[7:0]=8'hA5, memdata=8'hA5, stall high 4 cycles.
REQ-037 Four back-to-back reads irwrite 0001/0010/0100/1000, data 8'h20/8'h00/8'h01/8'h80 -> instr=32'h80010020, op=6'b100000.
REQ-038 memread=memwrite=1, adr=8'h44, writedata=8'h5A, ack next cycle -> mem_we=1, mem_wdata=8'h5A, memdata unchanged.
REQ-039 rst pulsed during BUSY -> mem_req=0 immediately, instr=0, later mem_ack has no effect.
REQ-040 With MEM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> after 4 BUSY cycles DONE, memdata=8'hFF, timeout=1 until rst; without macro mem_req stays high.
